// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 device transmitter:
//                FSM state encoding, frame length, default timing values and
//                the frame builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_BIT_HIGH = 3'd2,
    ST_BIT_LOW  = 3'd3,
    ST_FINISH   = 3'd4
  } ps2_state_t;

  localparam int C_FRAME_LEN            = 11;
  localparam int C_CLK_HALF_DIV_DEFAULT = 2000;
  localparam int C_IDLE_WAIT_DEFAULT    = 2500;

  // Frame bit 0 goes out first: start(0), data LSB first, odd parity, stop(1).
  function automatic logic [C_FRAME_LEN-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~(^data), data, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_sync
//  Description : Two-flop synchronizer for one open-collector PS/2 line.
//                Resets to 1, the released (pulled-up) line level.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic line_in,
  output logic line_sync
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous line level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= line_in;
      r_sync <= r_meta;
    end
  end

  assign line_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_device_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_device_transmitter
//  Description : PS/2 device-to-host byte transmitter. Waits for an idle bus,
//                then clocks out an 11-bit frame, generating the PS/2 clock
//                itself. Aborts when the host inhibits the clock mid-frame.
//                Build option PS2_TX_RETRY_EN: resend the aborted byte
//                (unlimited retries) instead of dropping it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_device_transmitter
  import ps2_pkg::*;
#(
  parameter int CLK_HALF_DIV = C_CLK_HALF_DIV_DEFAULT,
  parameter int IDLE_WAIT    = C_IDLE_WAIT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  input  logic       PS2ClkIn,
  output logic       PS2ClkOe,
  input  logic       PS2DataIn,
  output logic       PS2DataOe,
  output logic       TxDone,
  output logic       TxAbort
);

  localparam int                  C_HALF_W    = $clog2(CLK_HALF_DIV + 1);
  localparam int                  C_IDLE_W    = $clog2(IDLE_WAIT + 1);
  localparam logic [C_HALF_W-1:0] C_HALF_LAST = C_HALF_W'(CLK_HALF_DIV - 1);
  localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(IDLE_WAIT - 1);
  localparam logic [3:0]          C_FRAME_END = 4'(C_FRAME_LEN);

  ps2_state_t                 r_state;
  ps2_state_t                 w_state_nxt;
  logic [C_HALF_W-1:0]        r_half_cnt;
  logic [C_HALF_W-1:0]        w_half_cnt_nxt;
  logic [C_IDLE_W-1:0]        r_idle_cnt;
  logic [C_IDLE_W-1:0]        w_idle_cnt_nxt;
  logic [3:0]                 r_bit_idx;
  logic [3:0]                 w_bit_idx_nxt;
  logic [C_FRAME_LEN-1:0]     r_frame;
  logic [C_FRAME_LEN-1:0]     w_frame_nxt;
  logic                       r_live;
  logic                       r_clk_oe;
  logic                       r_data_oe;
  logic                       r_abort;
  logic                       w_clk_oe_nxt;
  logic                       w_data_oe_nxt;
  logic                       w_abort_nxt;
  logic                       w_cur_bit;
  logic                       w_clk_sync;
  logic                       w_data_sync;
  logic                       w_handshake;

  ps2_line_sync u_clk_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .line_in   (PS2ClkIn),
    .line_sync (w_clk_sync)
  );

  ps2_line_sync u_data_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .line_in   (PS2DataIn),
    .line_sync (w_data_sync)
  );

  // TxReady stays low during reset and rises on the first edge after it.
  assign TxReady     = r_live && (r_state == ST_IDLE);
  assign w_handshake = TxValid && TxReady;
  assign TxDone      = (r_state == ST_FINISH);
  assign TxAbort     = r_abort;
  assign PS2ClkOe    = r_clk_oe;
  assign PS2DataOe   = r_data_oe;

  // Next-state, counter and line-drive decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_half_cnt_nxt = r_half_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_frame_nxt    = r_frame;
    w_abort_nxt    = 1'b0;
    w_cur_bit      = 1'b1;
    w_clk_oe_nxt   = 1'b0;
    w_data_oe_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_bit_idx_nxt  = '0;
        w_half_cnt_nxt = '0;
        if (w_handshake) begin
          w_frame_nxt    = build_frame(TxData);
          w_idle_cnt_nxt = '0;
          w_state_nxt    = ST_WAIT_BUS;
        end
      end

      ST_WAIT_BUS: begin
        w_bit_idx_nxt  = '0;
        w_half_cnt_nxt = '0;
        if (!w_clk_sync || !w_data_sync) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == C_IDLE_LAST) begin
          w_idle_cnt_nxt = '0;
          w_state_nxt    = ST_BIT_HIGH;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + C_IDLE_W'(1);
        end
      end

      ST_BIT_HIGH: begin
        if (r_half_cnt == C_HALF_LAST) begin
          w_half_cnt_nxt = '0;
          // Clock low while released means the host is inhibiting.
          if (!w_clk_sync) begin
            w_abort_nxt    = 1'b1;
            w_bit_idx_nxt  = '0;
            w_idle_cnt_nxt = '0;
`ifdef PS2_TX_RETRY_EN
            w_state_nxt    = ST_WAIT_BUS;
`else
            w_state_nxt    = ST_IDLE;
`endif
          end else begin
            w_state_nxt = ST_BIT_LOW;
          end
        end else begin
          w_half_cnt_nxt = r_half_cnt + C_HALF_W'(1);
        end
      end

      ST_BIT_LOW: begin
        if (r_half_cnt == C_HALF_LAST) begin
          w_half_cnt_nxt = '0;
          w_bit_idx_nxt  = r_bit_idx + 4'd1;
          if (w_bit_idx_nxt == C_FRAME_END) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_BIT_HIGH;
          end
        end else begin
          w_half_cnt_nxt = r_half_cnt + C_HALF_W'(1);
        end
      end

      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Line drives are registered from the next state so they never glitch.
    if (w_bit_idx_nxt < C_FRAME_END) begin
      w_cur_bit = w_frame_nxt[w_bit_idx_nxt];
    end
    w_clk_oe_nxt  = (w_state_nxt == ST_BIT_LOW);
    w_data_oe_nxt = ((w_state_nxt == ST_BIT_HIGH) || (w_state_nxt == ST_BIT_LOW)) && !w_cur_bit;
  end

  // State, counters and registered outputs; reset releases both lines at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= '0;
      r_idle_cnt <= '0;
      r_bit_idx  <= '0;
      r_frame    <= '0;
      r_live     <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_half_cnt <= w_half_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_frame    <= w_frame_nxt;
      r_live     <= 1'b1;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_device_transmitter
//  Description : Scoreboard bench for ps2_device_transmitter. The driver
//                pushes expected frame/abort events; a monitor decodes the
//                open-collector bus and compares on TxDone/TxAbort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_device_transmitter;

  localparam int HALF   = 16;
  localparam int IDLE   = 40;
  localparam int BUDGET = 2 * 11 * HALF + 6 * IDLE + 400;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       TxValid = 1'b0;
  logic       TxReady;
  logic       PS2ClkOe;
  logic       PS2DataOe;
  logic       TxDone;
  logic       TxAbort;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       clk_line;
  logic       data_line;

  assign clk_line  = !(PS2ClkOe || host_clk_low);
  assign data_line = !(PS2DataOe || host_data_low);

  ps2_device_transmitter #(
    .CLK_HALF_DIV (HALF),
    .IDLE_WAIT    (IDLE)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .PS2ClkIn  (clk_line),
    .PS2ClkOe  (PS2ClkOe),
    .PS2DataIn (data_line),
    .PS2DataOe (PS2DataOe),
    .TxDone    (TxDone),
    .TxAbort   (TxAbort)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_abort;
    int          nbits;
    logic [10:0] bits;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  // Monitor state
  int          bit_cnt   = 0;
  logic [10:0] acc       = '0;
  bit          prev_clk  = 1'b1;
  int          low_cnt   = 0;
  bit          host_seen = 1'b0;
  int          run       = 0;
  int          last_run  = 0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic ev_t mk(input bit ab, input int nb, input logic [10:0] b);
    ev_t e;
    e.is_abort = ab;
    e.nbits    = nb;
    e.bits     = b;
    return e;
  endfunction

  // Monitor: decode falling clock edges, pulse widths and idle gaps; pop
  // the scoreboard whenever the DUT reports a finished or aborted frame.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        bit_cnt   = 0;
        acc       = '0;
        prev_clk  = 1'b1;
        low_cnt   = 0;
        host_seen = 1'b0;
      end else begin
        if (prev_clk && !clk_line) begin
          if (bit_cnt == 0) check("idle_gap", last_run >= IDLE, last_run, IDLE);
          if (bit_cnt < 11) acc[bit_cnt] = data_line;
          bit_cnt++;
          low_cnt   = 0;
          host_seen = 1'b0;
        end
        if (!clk_line) begin
          low_cnt++;
          if (host_clk_low) host_seen = 1'b1;
        end
        if (!prev_clk && clk_line && bit_cnt > 0 && !host_seen)
          check("low_width", low_cnt == HALF, low_cnt, HALF);
        prev_clk = clk_line;

        if (TxDone || TxAbort) begin
          check("done_abort_exclusive", !(TxDone && TxAbort), int'({TxDone, TxAbort}), 2);
          check("event_expected", exp_q.size() != 0, exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_kind", e.is_abort == TxAbort, int'(TxAbort), int'(e.is_abort));
            check("bit_count", bit_cnt == e.nbits, bit_cnt, e.nbits);
            check("frame_bits", acc == e.bits, int'(acc), int'(e.bits));
          end
          if (TxAbort)
            check("abort_release", !PS2ClkOe && !PS2DataOe, int'({PS2ClkOe, PS2DataOe}), 0);
          bit_cnt = 0;
          acc     = '0;
        end
      end
      if (clk_line && data_line) begin
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    int n = 0;
    tick(1);
    TxData  = b;
    TxValid = 1'b1;
    while (!TxReady && n < BUDGET) begin
      tick(1);
      n++;
    end
    check("handshake_timeout", TxReady, int'(TxReady), 1);
    tick(1);
    if (!keep) TxValid = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (!(exp_q.size() == 0 && TxReady) && n < BUDGET) begin
      tick(1);
      n++;
    end
    check("completion_timeout", exp_q.size() == 0 && TxReady, exp_q.size(), 0);
  endtask

  task automatic wait_bits(input int want);
    int n = 0;
    while (bit_cnt != want && n < BUDGET) begin
      tick(1);
      n++;
    end
    check("bit_wait_timeout", bit_cnt == want, bit_cnt, want);
  endtask

  task automatic wait_q(input int want);
    int n = 0;
    while (exp_q.size() != want && n < BUDGET) begin
      tick(1);
      n++;
    end
    check("abort_wait_timeout", exp_q.size() == want, exp_q.size(), want);
  endtask

  initial begin : driver
    // Reset state
    tick(3);
    check("rst_ready", TxReady == 1'b0, int'(TxReady), 0);
    check("rst_clk_oe", PS2ClkOe == 1'b0, int'(PS2ClkOe), 0);
    check("rst_data_oe", PS2DataOe == 1'b0, int'(PS2DataOe), 0);
    check("rst_done", TxDone == 1'b0, int'(TxDone), 0);
    check("rst_abort", TxAbort == 1'b0, int'(TxAbort), 0);
    Reset = 1'b1;
    #1;
    check("ready_before_edge", TxReady == 1'b0, int'(TxReady), 0);
    tick(1);
    check("ready_first_edge", TxReady == 1'b1, int'(TxReady), 1);

    // Plain frames: 0xFA, parity cases 0x01 / 0x00
    exp_q.push_back(mk(1'b0, 11, 11'h7F4));
    send(8'hFA, 1'b0);
    wait_quiet();
    exp_q.push_back(mk(1'b0, 11, 11'h402));
    send(8'h01, 1'b0);
    wait_quiet();
    exp_q.push_back(mk(1'b0, 11, 11'h600));
    send(8'h00, 1'b0);
    wait_quiet();

    // Host inhibit during bit 4 of 0x55
    exp_q.push_back(mk(1'b1, 5, 11'h00A));
`ifdef PS2_TX_RETRY_EN
    exp_q.push_back(mk(1'b0, 11, 11'h6AA));
`endif
    send(8'h55, 1'b0);
    wait_bits(5);
    host_clk_low = 1'b1;
`ifdef PS2_TX_RETRY_EN
    wait_q(1);
    tick(10);
    check("busy_during_retry", TxReady == 1'b0, int'(TxReady), 0);
    host_clk_low = 1'b0;
    wait_quiet();
`else
    wait_q(0);
    check("ready_after_abort", TxReady == 1'b1, int'(TxReady), 1);
    tick(10);
    host_clk_low = 1'b0;
    tick(2 * IDLE + 2 * HALF + 20);
    check("no_resend", bit_cnt == 0, bit_cnt, 0);
`endif

    // Host holds data low at handshake: no clock until bus idle
    host_data_low = 1'b1;
    exp_q.push_back(mk(1'b0, 11, 11'h6B4));
    send(8'h5A, 1'b0);
    tick(3 * IDLE);
    check("no_clock_data_low", bit_cnt == 0 && !PS2ClkOe, bit_cnt, 0);
    host_data_low = 1'b0;
    wait_quiet();

    // Reset pulse at bit 6 of 0xA3: line release is immediate
    send(8'hA3, 1'b0);
    wait_bits(7);
    #2 Reset = 1'b0;
    #1;
    check("reset_release", !PS2ClkOe && !PS2DataOe, int'({PS2ClkOe, PS2DataOe}), 0);
    check("reset_ready_low", TxReady == 1'b0, int'(TxReady), 0);
    tick(3);
    Reset = 1'b1;
    tick(1);
    check("ready_after_reset", TxReady == 1'b1, int'(TxReady), 1);

    // TxValid held high across two bytes
    exp_q.push_back(mk(1'b0, 11, 11'h622));
    exp_q.push_back(mk(1'b0, 11, 11'h644));
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    wait_quiet();

    tick(20);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_device_transmitter.md
PS2_DEVICE_TRANSMITTER -- requirements
Module: ps2_device_transmitter

Interface
REQ-001 Parameter CLK_HALF_DIV, default 2000: Clk cycles per PS/2 clock half-period (12.5 kHz at 50 MHz).
REQ-002 Parameter IDLE_WAIT, default 2500: Clk cycles both bus lines SHALL read high before a frame starts (50 us).
REQ-003 Clk  input  1  system clock, all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 TxData  input  8  byte to send.
REQ-006 TxValid  input  1  TxData valid.
REQ-007 TxReady  output  1  block accepts a byte; transfer occurs on a cycle with TxValid and TxReady both high.
REQ-008 PS2ClkIn  input  1  raw PS/2 clock line level.
REQ-009 PS2ClkOe  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-010 PS2DataIn  input  1  raw PS/2 data line level.
REQ-011 PS2DataOe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-012 TxDone  output  1  one-cycle pulse after the stop bit's clock pulse completes.
REQ-013 TxAbort  output  1  one-cycle pulse when the host inhibits mid-frame.

Function
REQ-014 PS2ClkIn and PS2DataIn SHALL pass through 2-flop synchronizers; all decisions use synchronized values.
REQ-015 States: IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, FINISH.
REQ-016 IDLE: TxReady=1, both Oe=0; on handshake, latch TxData, build 11-bit frame, go to WAIT_BUS.
REQ-017 Frame: start 0, data LSB first, odd parity (data ones + parity bit is odd), stop 1.
REQ-018 WAIT_BUS: counter reloads whenever either synchronized line is low; after IDLE_WAIT consecutive high cycles, go to BIT_HIGH with bit index 0.
REQ-019 BIT_HIGH: PS2DataOe = NOT current frame bit, PS2ClkOe=0, for CLK_HALF_DIV cycles; go to BIT_LOW.
REQ-020 At the last cycle of BIT_HIGH, a low synchronized clock (host inhibit) SHALL abort: both Oe=0, TxAbort pulses, go to WAIT_BUS or IDLE per REQ-030.
REQ-021 BIT_LOW: PS2ClkOe=1, data held, for CLK_HALF_DIV cycles; then increment bit index; index 11 -> FINISH, else BIT_HIGH.
REQ-022 FINISH: both Oe=0, TxDone pulses for one cycle, return to IDLE.
REQ-023 TxReady SHALL be 0 in every state except IDLE; TxValid outside IDLE is ignored.
REQ-024 Inhibit during BIT_LOW is not detectable (the block drives the clock low) and SHALL be checked at the following BIT_HIGH end; inhibit after the stop bit's BIT_LOW is not an abort.
REQ-025 TxDone and TxAbort SHALL never assert in the same cycle.
REQ-026 Half-period counter SHALL be sized ceil(log2(CLK_HALF_DIV+1)) bits and SHALL not wrap within a phase.

Reset
REQ-027 While Reset=0: state IDLE, TxReady=0, PS2ClkOe=0, PS2DataOe=0, TxDone=0, TxAbort=0, counters and bit index 0, synchronizers 1.
REQ-028 TxReady SHALL rise on the first Clk edge after Reset deasserts.
REQ-029 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) and discard the byte without TxAbort.

Configuration
REQ-030 PS2_TX_RETRY_EN defined: after abort, the latched byte SHALL be resent from WAIT_BUS, unlimited retries; undefined: after abort, the byte is dropped and state returns to IDLE.

Structure
REQ-031 Shared package ps2_pkg SHALL hold the state enum, frame length constant 11, and default CLK_HALF_DIV/IDLE_WAIT values.
REQ-032 Sub-module ps2_line_sync SHALL implement the 2-flop synchronizer, instantiated once per line.

Verification
REQ-033 Send 0xFA, bus idle -> data levels per falling clock edge 0,0,1,0,1,1,1,1,1,1,1; TxDone once; 11 clock low pulses, each 2000 cycles.
REQ-034 Send 0x01 -> parity bit 0; send 0x00 -> parity bit 1.
REQ-035 Host holds clock low during bit 4 of 0x55 -> TxAbort pulse, lines released; with PS2_TX_RETRY_EN, full 0x55 frame resent after clock released plus 2500 cycles; without, TxReady=1 and no resend.
REQ-036 Data held low by host at handshake -> no clock pulses until 2500 cycles after release.
REQ-037 Reset pulsed at bit 6 -> both Oe=0 immediately, no TxDone/TxAbort, TxReady=1 after release.
REQ-038 TxValid held high continuously with 0x11, 0x22 -> back-to-back frames, each separated by at least 2500 idle cycles.
